// File: rtl/mem_access_ctrl_if.sv
// Handshake bundle between the control unit, the MAR/MDR pair and memory,
// driven by mem_access_ctrl through the slave modport.
interface mem_access_ctrl_if;
   logic req;
   logic req_we;
   logic mem_ack;
   logic busy;
   logic done;
   logic err;
   logic MARin;
   logic MDRin;
   logic Read;
   logic mem_rd;
   logic mem_wr;

   modport master (
      output req, req_we, mem_ack,
      input  busy, done, err, MARin, MDRin, Read, mem_rd, mem_wr
   );

   modport slave (
      input  req, req_we, mem_ack,
      output busy, done, err, MARin, MDRin, Read, mem_rd, mem_wr
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences one MAR/MDR memory load or store: address phase, bounded wait
// for mem_ack, then a one-cycle done (with err on timeout).
module mem_access_ctrl #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 4
) (
   input  logic              clk,
   input  logic              clr,
   mem_access_ctrl_if.slave  bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

   logic [2:0]       state_q, state_d;
   logic             we_q, we_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      cnt_d      = cnt_q;
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      bus.err    = 1'b0;
      bus.MARin  = 1'b0;
      bus.MDRin  = 1'b0;
      bus.Read   = 1'b0;
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               state_d = S_ADDR;
               we_d    = bus.req_we;
            end
         end
         S_ADDR: begin
            bus.MARin = 1'b1;
            bus.busy  = 1'b1;
            cnt_d     = '0;
            state_d   = we_q ? S_WR : S_RD;
         end
         S_RD: begin
            bus.busy   = 1'b1;
            bus.mem_rd = 1'b1;
            bus.Read   = 1'b1;
            // MDR captures Mdatain on the same edge that ack is seen
            bus.MDRin  = bus.mem_ack;
            if (bus.mem_ack)            state_d = S_DONE;
            else if (cnt_q == CNT_LAST) state_d = S_ERR;
            else                        cnt_d   = cnt_q + CNT_W'(1);
         end
         S_WR: begin
            bus.busy   = 1'b1;
            bus.mem_wr = 1'b1;
            if (bus.mem_ack)            state_d = S_DONE;
            else if (cnt_q == CNT_LAST) state_d = S_ERR;
            else                        cnt_d   = cnt_q + CNT_W'(1);
         end
         S_DONE: begin
            bus.done = 1'b1;
            state_d  = S_IDLE;
         end
         S_ERR: begin
            bus.done = 1'b1;
            bus.err  = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
